tri_raster_scan: RTL
====================

Name: tri_raster_scan

Overview:
- Raster sweep stage that sits directly in front of the point-in-triangle tester.
- Given triangle vertices A, B, C on the 640x480 grid, it computes the clamped bounding box and walks it row-major, one pixel at a time.
- Each point (Px, Py) is issued to the tester over a valid/ready handshake, and the block waits for the tester's inside/outside verdict.
- Each verdict is written to the framebuffer as a 1-bit pixel write. The block also keeps a running count of inside pixels.

Parameters:
- XW, 11, x coordinate width.
- YW, 10, y coordinate width.
- XMAX, 639, last valid column.
- YMAX, 479, last valid row.
- AW, 19, framebuffer address width (640*480 = 307200 < 2^19).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  launch one sweep; sampled only in IDLE.
- ax, bx, cx  in  XW each  vertex x coordinates, unsigned.
- ay, by, cy  in  YW each  vertex y coordinates, unsigned.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  single-cycle pulse when the sweep ends.
- pt_valid  out  1  point request valid.
- pt_ready  in  1  tester accepts the point.
- pt_x  out  XW  point x.
- pt_y  out  YW  point y.
- res_valid  in  1  tester verdict valid.
- res_inside  in  1  verdict: 1 = inside or on an edge.
- pix_we  out  1  framebuffer write strobe.
- pix_addr  out  AW  write address, y*(XMAX+1)+x.
- pix_data  out  1  pixel value, equal to the verdict.
- inside_cnt  out  AW  number of inside verdicts in the current or last sweep.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE. busy, done, pt_valid and pix_we are 0. pt_x, pt_y, pix_addr, pix_data and inside_cnt are 0.
- Reset mid-sweep aborts immediately. No partial done pulse is produced.
- FSM states: IDLE, BBOX, ISSUE, WAIT, WRITE, DONE.
- IDLE:
  - start=1 latches all six vertex inputs and moves to BBOX.
  - inside_cnt clears to 0 on that same edge.
  - start outside IDLE is ignored.
- BBOX (1 cycle):
  - xmin/xmax = min/max of ax, bx, cx; ymin/ymax likewise for y.
  - Every coordinate is clamped to XMAX/YMAX before min/max, so the box is always non-empty.
  - Loads x=xmin, y=ymin and row_base=ymin*(XMAX+1). The multiply is allowed here only.
  - Moves to ISSUE.
- ISSUE:
  - pt_valid=1, pt_x=x, pt_y=y, held stable until pt_ready=1.
  - On the accepting edge (pt_valid & pt_ready), moves to WAIT. pt_valid drops the next cycle.
- WAIT:
  - Holds until res_valid=1, then latches res_inside and moves to WRITE.
  - res_valid in any other state is ignored.
  - A verdict arriving in the same cycle as acceptance is not captured. The tester must present it no earlier than the cycle after acceptance.
- WRITE (exactly 1 cycle):
  - pix_we=1, pix_addr=row_base+x, pix_data=verdict.
  - inside_cnt increments if the verdict is 1.
  - Advance rules:
    - If x<xmax: x++.
    - Else if y<ymax: x=xmin, y++, row_base += XMAX+1.
    - Else: go to DONE.
  - Otherwise return to ISSUE.
- DONE: done=1 for one cycle, busy=0 on the following cycle, then IDLE. inside_cnt holds until the next start.
- Throughput: minimum 3 cycles per pixel (ISSUE, WAIT, WRITE) when pt_ready is high and res_valid arrives in the first WAIT cycle.
- Total cycles from start to done for an ideal responder: 1 + 1 + 3*N + 1, where N = (xmax-xmin+1)*(ymax-ymin+1).
- Arithmetic:
  - Address add is unsigned AW bits; no overflow is possible within 640x480.
  - inside_cnt is AW bits and saturates at neither end; its maximum, 307200, fits.
- Degenerate triangles (collinear or coincident vertices) are swept normally; the tester decides the verdict.

Decomposition:
- Shared package holds:
  - XW, YW, XMAX, YMAX, AW constants.
  - FSM state encoding, 3 bits.
  - SCREEN_W = XMAX+1.
- One natural sub-module, bbox_clamp: combinational clamp plus min/max of three coordinates, instanced once for x and once for y.

Test Plan:
- Vertices (0,0),(5,5),(10,0); responder ready=1, verdict 1 cycle after accept, inside iff y<=x and y<=10-x.
  -> 66 writes, first addr 0, last addr 3210, inside_cnt=36, done at cycle 2+198+1 after start.
- Vertices (700,10),(650,20),(639,15).
  -> x clamped to 639..639, y 10..20, 11 writes, addrs 7039 to 13439 in steps of 640.
- pt_ready held low 4 cycles on the first point.
  -> pt_valid and pt_x/pt_y stable throughout, no write until acceptance, then 1 write.
- Spurious res_valid=1 while in IDLE and in ISSUE.
  -> no pix_we, inside_cnt unchanged.
- rst asserted during the 10th pixel of scenario 1.
  -> all outputs 0 within the same cycle, no done. A new start reruns the full sweep with inside_cnt restarting at 0.
- start pulsed again while busy.
  -> ignored, sweep completes with the original vertices.

Source files
------------

// File: rtl/tri_raster_scan_pkg.sv
// rtl/tri_raster_scan_pkg.sv - shared constants and FSM encoding for the raster sweep
package tri_raster_scan_pkg;

   localparam int XW       = 11;
   localparam int YW       = 10;
   localparam int XMAX     = 639;
   localparam int YMAX     = 479;
   localparam int AW       = 19;
   localparam int SCREEN_W = XMAX + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_BBOX  = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5
   } state_e;

endpackage

// File: rtl/tri_raster_scan_if.sv
// rtl/tri_raster_scan_if.sv - point/verdict handshake and framebuffer write channel
interface tri_raster_scan_if;
   import tri_raster_scan_pkg::*;

   logic          pt_valid;
   logic          pt_ready;
   logic [XW-1:0] pt_x;
   logic [YW-1:0] pt_y;
   logic          res_valid;
   logic          res_inside;
   logic          pix_we;
   logic [AW-1:0] pix_addr;
   logic          pix_data;

   modport master (
      output pt_valid, pt_x, pt_y, pix_we, pix_addr, pix_data,
      input  pt_ready, res_valid, res_inside
   );

   modport slave (
      input  pt_valid, pt_x, pt_y, pix_we, pix_addr, pix_data,
      output pt_ready, res_valid, res_inside
   );

endinterface

// File: rtl/tri_raster_scan_bbox_clamp.sv
// rtl/tri_raster_scan_bbox_clamp.sv - clamp three coordinates to the screen edge, then min/max
module tri_raster_scan_bbox_clamp #(
   parameter int W   = 11,
   parameter int LIM = 639
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] c_i,
   output logic [W-1:0] min_o,
   output logic [W-1:0] max_o
);

   logic [W-1:0] a_c;
   logic [W-1:0] b_c;
   logic [W-1:0] c_c;

   always_comb begin
      a_c = (a_i > W'(LIM)) ? W'(LIM) : a_i;
      b_c = (b_i > W'(LIM)) ? W'(LIM) : b_i;
      c_c = (c_i > W'(LIM)) ? W'(LIM) : c_i;

      min_o = a_c;
      if (b_c < min_o) min_o = b_c;
      if (c_c < min_o) min_o = c_c;

      max_o = a_c;
      if (b_c > max_o) max_o = b_c;
      if (c_c > max_o) max_o = c_c;
   end

endmodule

// File: rtl/tri_raster_scan.sv
// rtl/tri_raster_scan.sv - row-major bounding-box sweep issuing points and writing 1-bit verdicts
module tri_raster_scan
   import tri_raster_scan_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [XW-1:0]    ax,
   input  logic [XW-1:0]    bx,
   input  logic [XW-1:0]    cx,
   input  logic [YW-1:0]    ay,
   input  logic [YW-1:0]    by,
   input  logic [YW-1:0]    cy,
   output logic             busy,
   output logic             done,
   output logic [AW-1:0]    inside_cnt,
   tri_raster_scan_if.master bus
);

   state_e        state_q, state_d;
   logic [XW-1:0] ax_q, ax_d, bx_q, bx_d, cx_q, cx_d;
   logic [YW-1:0] ay_q, ay_d, by_q, by_d, cy_q, cy_d;
   logic [XW-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
   logic [YW-1:0] ymax_q, ymax_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [AW-1:0] row_base_q, row_base_d;
   logic          verdict_q, verdict_d;
   logic [AW-1:0] cnt_q, cnt_d;

   logic [XW-1:0] bb_xmin, bb_xmax;
   logic [YW-1:0] bb_ymin, bb_ymax;

   tri_raster_scan_bbox_clamp #(.W(XW), .LIM(XMAX)) u_bbox_x (
      .a_i   (ax_q),
      .b_i   (bx_q),
      .c_i   (cx_q),
      .min_o (bb_xmin),
      .max_o (bb_xmax)
   );

   tri_raster_scan_bbox_clamp #(.W(YW), .LIM(YMAX)) u_bbox_y (
      .a_i   (ay_q),
      .b_i   (by_q),
      .c_i   (cy_q),
      .min_o (bb_ymin),
      .max_o (bb_ymax)
   );

   always_comb begin
      state_d    = state_q;
      ax_d       = ax_q;
      bx_d       = bx_q;
      cx_d       = cx_q;
      ay_d       = ay_q;
      by_d       = by_q;
      cy_d       = cy_q;
      xmin_d     = xmin_q;
      xmax_d     = xmax_q;
      ymax_d     = ymax_q;
      x_d        = x_q;
      y_d        = y_q;
      row_base_d = row_base_q;
      verdict_d  = verdict_q;
      cnt_d      = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               ax_d    = ax;
               bx_d    = bx;
               cx_d    = cx;
               ay_d    = ay;
               by_d    = by;
               cy_d    = cy;
               cnt_d   = '0;
               state_d = S_BBOX;
            end
         end
         S_BBOX: begin
            // The only multiply: later rows advance row_base by addition.
            xmin_d     = bb_xmin;
            xmax_d     = bb_xmax;
            ymax_d     = bb_ymax;
            x_d        = bb_xmin;
            y_d        = bb_ymin;
            row_base_d = AW'(bb_ymin) * AW'(SCREEN_W);
            state_d    = S_ISSUE;
         end
         S_ISSUE: begin
            if (bus.pt_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.res_valid) begin
               verdict_d = bus.res_inside;
               state_d   = S_WRITE;
            end
         end
         S_WRITE: begin
            if (verdict_q) cnt_d = cnt_q + AW'(1);
            if (x_q < xmax_q) begin
               x_d     = x_q + XW'(1);
               state_d = S_ISSUE;
            end else if (y_q < ymax_q) begin
               x_d        = xmin_q;
               y_d        = y_q + YW'(1);
               row_base_d = row_base_q + AW'(SCREEN_W);
               state_d    = S_ISSUE;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ax_q       <= '0;
         bx_q       <= '0;
         cx_q       <= '0;
         ay_q       <= '0;
         by_q       <= '0;
         cy_q       <= '0;
         xmin_q     <= '0;
         xmax_q     <= '0;
         ymax_q     <= '0;
         x_q        <= '0;
         y_q        <= '0;
         row_base_q <= '0;
         verdict_q  <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         ax_q       <= ax_d;
         bx_q       <= bx_d;
         cx_q       <= cx_d;
         ay_q       <= ay_d;
         by_q       <= by_d;
         cy_q       <= cy_d;
         xmin_q     <= xmin_d;
         xmax_q     <= xmax_d;
         ymax_q     <= ymax_d;
         x_q        <= x_d;
         y_q        <= y_d;
         row_base_q <= row_base_d;
         verdict_q  <= verdict_d;
         cnt_q      <= cnt_d;
      end
   end

   assign busy         = (state_q != S_IDLE);
   assign done         = (state_q == S_DONE);
   assign bus.pt_valid = (state_q == S_ISSUE);
   assign bus.pt_x     = x_q;
   assign bus.pt_y     = y_q;
   assign bus.pix_we   = (state_q == S_WRITE);
   assign bus.pix_addr = row_base_q + AW'(x_q);
   assign bus.pix_data = verdict_q;
   assign inside_cnt   = cnt_q;

endmodule
